// File: rtl/vga_timing.sv
// Raster timing generator: divides clk into a pixel strobe, runs the h/v counters
// and registers sync, coordinate and line/frame/sprite strobes from the next-state values.
module vga_timing #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] spr_y,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start,
    output logic       spr_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       SYNC_ON  = 1'(SYNC_POL);
    localparam logic [9:0] BLANK_XY = 10'h3FF;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [9:0]       r_h_count;
    logic [9:0]       r_v_count;
    logic [9:0]       w_h_nxt;
    logic [9:0]       w_v_nxt;
    logic             w_tick_nxt;
    logic             w_h_wrap;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_video_nxt;
    logic [9:0]       w_px_nxt;
    logic [9:0]       w_py_nxt;
    logic             w_frame_nxt;
    logic             w_spr_nxt;

    // Next-state counters and decodes; outputs describe the counters they are registered with.
    always_comb begin
        w_div_nxt = (r_div == DIV_LAST) ? DIV_W'(0) : r_div + DIV_W'(1);
        w_tick_nxt = (w_div_nxt == DIV_LAST);
        w_h_wrap  = pix_tick && (r_h_count == H_LAST);
        w_h_nxt   = r_h_count;
        w_v_nxt   = r_v_count;
        if (pix_tick) begin
            w_h_nxt = w_h_wrap ? 10'd0 : r_h_count + 10'd1;
        end else begin
            w_h_nxt = r_h_count;
        end
        if (w_h_wrap) begin
            w_v_nxt = (r_v_count == V_LAST) ? 10'd0 : r_v_count + 10'd1;
        end else begin
            w_v_nxt = r_v_count;
        end
        w_hsync_nxt = ((w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END)) ? SYNC_ON : ~SYNC_ON;
        w_vsync_nxt = ((w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END)) ? SYNC_ON : ~SYNC_ON;
        w_video_nxt = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
        w_px_nxt    = (w_h_nxt < H_ACT) ? w_h_nxt : BLANK_XY;
        w_py_nxt    = (w_v_nxt < V_ACT) ? w_v_nxt : BLANK_XY;
        w_frame_nxt = w_h_wrap && (w_v_nxt == 10'd0);
        // Off-screen rows never match, even though v_count itself reaches them.
        w_spr_nxt   = w_h_wrap && (spr_y == w_v_nxt) && (spr_y < V_ACT);
    end

    // State and output registers with asynchronous reset to the pre-frame position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div       <= DIV_W'(0);
            r_h_count   <= H_LAST;
            r_v_count   <= V_LAST;
            pix_tick    <= 1'b0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            video_on    <= 1'b0;
            pixel_x     <= BLANK_XY;
            pixel_y     <= BLANK_XY;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            spr_start   <= 1'b0;
        end else begin
            r_div       <= w_div_nxt;
            r_h_count   <= w_h_nxt;
            r_v_count   <= w_v_nxt;
            pix_tick    <= w_tick_nxt;
            hsync       <= w_hsync_nxt;
            vsync       <= w_vsync_nxt;
            video_on    <= w_video_nxt;
            pixel_x     <= w_px_nxt;
            pixel_y     <= w_py_nxt;
            line_start  <= w_h_wrap;
            frame_start <= w_frame_nxt;
            spr_start   <= w_spr_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (default 640x480, a shrunken raster, and CLK_DIV=1)
// compared every cycle against a cycle-count based reference model, with random spr_y and resets.
module tb_vga_timing;

    localparam int SD = 2, SHA = 16, SHF = 2, SHS = 3, SHB = 4;
    localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;

    typedef struct packed {
        logic       tick;
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] px;
        logic [9:0] py;
        logic       ls;
        logic       fs;
        logic       ss;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] spr_b = 10'd100;
    logic [9:0] spr_s = 10'd12;
    logic [9:0] sb_e = 10'd100;
    logic [9:0] ss_e = 10'd12;
    int         t = 0;
    int         n_checks = 0;
    int         n_err = 0;

    logic       b_tick, b_hs, b_vs, b_von, b_ls, b_fs, b_ss;
    logic [9:0] b_px, b_py;
    logic       s_tick, s_hs, s_vs, s_von, s_ls, s_fs, s_ss;
    logic [9:0] s_px, s_py;
    logic       f_tick, f_hs, f_vs, f_von, f_ls, f_fs, f_ss;
    logic [9:0] f_px, f_py;

    always #5 clk = ~clk;

    vga_timing u_big (
        .clk(clk), .rst(rst), .spr_y(spr_b),
        .pix_tick(b_tick), .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
        .pixel_x(b_px), .pixel_y(b_py),
        .line_start(b_ls), .frame_start(b_fs), .spr_start(b_ss)
    );

    vga_timing #(
        .CLK_DIV(SD), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(0)
    ) u_small (
        .clk(clk), .rst(rst), .spr_y(spr_s),
        .pix_tick(s_tick), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .pixel_x(s_px), .pixel_y(s_py),
        .line_start(s_ls), .frame_start(s_fs), .spr_start(s_ss)
    );

    vga_timing #(
        .CLK_DIV(1), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(0)
    ) u_fast (
        .clk(clk), .rst(rst), .spr_y(spr_s),
        .pix_tick(f_tick), .hsync(f_hs), .vsync(f_vs), .video_on(f_von),
        .pixel_x(f_px), .pixel_y(f_py),
        .line_start(f_ls), .frame_start(f_fs), .spr_start(f_ss)
    );

    // Number of pixel advances completed before cycle tc (cycle 0 = first cycle after release).
    function automatic int n_adv(input int d, input int tc);
        if (tc <= 0) return 0;
        if (d == 1) return tc - 1;
        return tc / d;
    endfunction

    // Expected outputs in cycle tc, derived from the raster rules directly.
    function automatic obs_t model(input int d, input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp,
                                   input int tc, input int spr, input logic in_rst);
        obs_t e;
        int ht, vt, a, p, h, v;
        logic adv;
        e = '{tick: 1'b0, hs: 1'b1, vs: 1'b1, von: 1'b0, px: 10'h3FF, py: 10'h3FF,
              ls: 1'b0, fs: 1'b0, ss: 1'b0};
        if (in_rst) return e;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        e.tick = (d == 1) ? (tc >= 1) : ((tc % d) == (d - 1));
        a = n_adv(d, tc);
        if (a == 0) return e;
        p = (a - 1) % (ht * vt);
        h = p % ht;
        v = p / ht;
        adv = (a != n_adv(d, tc - 1));
        e.hs  = !((h >= ha + hfp) && (h < ha + hfp + hsw));
        e.vs  = !((v >= va + vfp) && (v < va + vfp + vsw));
        e.von = (h < ha) && (v < va);
        e.px  = (h < ha) ? 10'(h) : 10'h3FF;
        e.py  = (v < va) ? 10'(v) : 10'h3FF;
        e.ls  = adv && (h == 0);
        e.fs  = e.ls && (v == 0);
        e.ss  = e.ls && (v == spr) && (spr < va);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic compare_all();
        obs_t ob, os, of;
        ob = '{b_tick, b_hs, b_vs, b_von, b_px, b_py, b_ls, b_fs, b_ss};
        os = '{s_tick, s_hs, s_vs, s_von, s_px, s_py, s_ls, s_fs, s_ss};
        of = '{f_tick, f_hs, f_vs, f_von, f_px, f_py, f_ls, f_fs, f_ss};
        check("big", 32'(ob), 32'(model(4, 640, 16, 96, 48, 480, 10, 2, 33, t, int'(sb_e), rst)));
        check("small", 32'(os), 32'(model(SD, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, t, int'(ss_e), rst)));
        check("div1", 32'(of), 32'(model(1, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, t, int'(ss_e), rst)));
    endtask

    // One clock: record what the design samples at the edge, then compare mid-cycle.
    task automatic step();
        @(posedge clk);
        sb_e = spr_b;
        ss_e = spr_s;
        if (!rst) t++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        #1;
        compare_all();
        repeat (n) step();
        rst = 1'b0;
        t = 0;
        #1;
        compare_all();
    endtask

    initial begin
        int fs_first, ls_a, ls_b, hs_low, s_fs_a, s_fs_b, s_ls_cnt, s_vs_low, spr_cnt, waited;
        fs_first = -1; ls_a = -1; ls_b = -1; hs_low = 0;
        s_fs_a = -1; s_fs_b = -1; s_ls_cnt = 0; s_vs_low = 0; spr_cnt = 0;

        repeat (3) @(negedge clk);
        compare_all();
        rst = 1'b0;
        t = 0;
        #1;
        compare_all();

        // Directed: first frame timing, a full default line, small-raster frames with spr_y off-screen.
        for (int i = 0; i < 7000; i++) begin
            step();
            if (b_fs && fs_first < 0) fs_first = t;
            if (b_ls) begin
                if (ls_a < 0) ls_a = t;
                else if (ls_b < 0) ls_b = t;
            end
            if (ls_a >= 0 && ls_b < 0 && !b_hs) hs_low++;
            if (s_fs) begin
                if (s_fs_a < 0) s_fs_a = t;
                else if (s_fs_b < 0) s_fs_b = t;
            end
            if (s_fs_a >= 0 && s_fs_b < 0) begin
                if (s_ls) s_ls_cnt++;
                if (!s_vs) s_vs_low++;
            end
            if (s_ss || f_ss) spr_cnt++;
        end
        check("first_frame_start_cycle", 32'(fs_first), 32'd4);
        check("line_period", 32'(ls_b - ls_a), 32'd3200);
        check("hsync_low_clks", 32'(hs_low), 32'd384);
        check("small_frame_period", 32'(s_fs_b - s_fs_a), 32'(SD * 25 * 19));
        check("small_lines_per_frame", 32'(s_ls_cnt), 32'd19);
        check("small_vsync_low_clks", 32'(s_vs_low), 32'(SD * 25 * SVS));
        check("offscreen_spr_count", 32'(spr_cnt), 32'd0);

        // Directed: move spr_y from row 3 to row 8 mid-line on row 6; expect one hit on row 8.
        spr_s = 10'd3;
        waited = 0;
        while (!(s_py == 10'd6 && s_px == 10'd5) && waited < 2000) begin
            step();
            waited++;
        end
        check("wait_row6", 32'(waited < 2000), 32'd1);
        spr_s = 10'd8;
        spr_cnt = 0;
        waited = 0;
        while (!s_fs && waited < 2000) begin
            step();
            waited++;
            if (s_ss) begin
                spr_cnt++;
                check("spr_row", 32'(s_py), 32'd8);
            end
        end
        check("wait_next_frame", 32'(waited < 2000), 32'd1);
        check("spr_hits_after_change", 32'(spr_cnt), 32'd1);

        // Random spr_y changes and reset pulses, all checked against the model every cycle.
        for (int i = 0; i < 30000; i++) begin
            step();
            if ($urandom_range(0, 39) == 0) begin
                spr_b = 10'($urandom_range(0, 12));
                spr_s = 10'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 499) == 0) pulse_reset(int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator for the VGA output path.
- Divides the system clock into a pixel strobe and runs horizontal/vertical counters for 640x480@60.
- Produces hsync/vsync, the pixel coordinates, and per-line/per-frame strobes.
- Issues the per-frame start pulse consumed by draw_sprite: draw_sprite receives pixel_x and uses spr_start as its start input.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1); 100 MHz / 4 = 25 MHz pixel rate.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- spr_y  in  10  sprite top row; sampled only at line-start edges.
- pix_tick  out  1  pixel strobe, high 1 clk every CLK_DIV clks.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- video_on  out  1  current pixel is in the visible area.
- pixel_x  out  10  column 0..H_ACTIVE-1 while in the active columns; 10'h3FF otherwise.
- pixel_y  out  10  row 0..V_ACTIVE-1 while in the active rows; 10'h3FF otherwise.
- line_start  out  1  1-clk pulse when h_count enters 0.
- frame_start  out  1  1-clk pulse when (h_count, v_count) enters (0, 0).
- spr_start  out  1  1-clk pulse at line start of row spr_y.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Internal counters: div (0..CLK_DIV-1), h_count (0..H_TOTAL-1), v_count (0..V_TOTAL-1).
- Divider:
  - div increments every clk and wraps at CLK_DIV-1.
  - pix_tick = (div == CLK_DIV-1), registered. With CLK_DIV=1, pix_tick is constantly 1 after reset.
- Counter advance: on a clk edge where pix_tick==1:
  - h_count increments, wrapping H_TOTAL-1 -> 0.
  - On that wrap, v_count increments, wrapping V_TOTAL-1 -> 0.
  - Counters hold on all other edges.
- Output timing:
  - Every output is a register.
  - Coordinate and sync outputs are updated on the same edge as the counters.
  - In any cycle, these outputs describe that cycle's h_count/v_count; no extra latency.
- Decodes:
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (656..751); ~SYNC_POL otherwise.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (490..491); ~SYNC_POL otherwise.
  - video_on = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
  - pixel_x = h_count when h_count < H_ACTIVE, else 10'h3FF. The 3FF value ensures no on-screen spr_x matches during blanking.
  - pixel_y = v_count when v_count < V_ACTIVE, else 10'h3FF.
- Strobes:
  - line_start, frame_start and spr_start assert for exactly one clk: the cycle following the advance edge that set h_count to 0.
  - They are deasserted on all other cycles regardless of CLK_DIV.
  - frame_start additionally requires v_count == 0.
  - spr_start requires spr_y == new v_count, sampled at that edge.
  - spr_y >= V_ACTIVE never produces spr_start.
  - spr_y changes between line starts have no effect until the next line start.
- Reset (async, immediate):
  - div = 0, h_count = H_TOTAL-1, v_count = V_TOTAL-1.
  - pix_tick = 0; hsync = vsync = ~SYNC_POL; video_on = 0.
  - pixel_x = pixel_y = 10'h3FF; all strobes 0.
  - The first advance therefore wraps to (0, 0) and fires frame_start.
- Reset mid-frame: all state returns to the reset values immediately. No partial-line strobe is emitted on release.

Test Plan:
- Reset with CLK_DIV=4, release -> pix_tick high in cycles 3, 7, 11, ... In cycle 4: frame_start=line_start=1, video_on=1, pixel_x=0, pixel_y=0. All strobes are 0 in cycle 5.
- Run one line -> pixel_x steps 0..639 (each value held 4 clks), then 3FF at h=640. hsync low for exactly 96 ticks starting at h=656. line_start period = 3200 clks.
- Run full frame -> vsync low on v_count 490 and 491 only. pixel_y = 3FF for rows 480..524. frame_start period = 1,680,000 clks; exactly 525 line_start pulses per frame.
- spr_y=100 -> spr_start exactly once per frame, coincident with line_start while pixel_y=100.
- spr_y=480 -> no spr_start over two frames. Change spr_y 100 -> 200 mid-line on row 150 -> next spr_start on row 200 of the same frame.
- Assert rst at h=300, v=200 for 2 clks, then release -> outputs at reset values immediately. After release, the sequence matches the first scenario exactly.
